// File: rtl/sbmips_stack_if.sv
// Operand-stack port bundle between the SBMIPS control/datapath and the stack.
interface sbmips_stack_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  logic                     push;
  logic                     pop;
  logic                     tos;
  logic [WIDTH-1:0]         din;
  logic [WIDTH-1:0]         dout;
  logic [$clog2(DEPTH):0]   count;
  logic                     empty;
  logic                     full;
  logic                     ovf;
  logic                     udf;

  modport master (output push, pop, tos, din,
                  input  dout, count, empty, full, ovf, udf);
  modport slave  (input  push, pop, tos, din,
                  output dout, count, empty, full, ovf, udf);
endinterface

// File: rtl/sbmips_stack.sv
// Hardware operand stack with registered top-of-stack read and sticky error flags.
module sbmips_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  sbmips_stack_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    sp;
  logic [WIDTH-1:0] dout_q;
  logic             ovf_q;
  logic             udf_q;

  logic             is_empty;
  logic             is_full;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;

  assign is_empty = (sp == '0);
  assign is_full  = (sp == CW'(DEPTH));
  // Low bits wrap correctly at sp == DEPTH, so top_idx is always DEPTH-1 when full.
  assign top_idx  = sp[AW-1:0] - AW'(1);
  assign wr_idx   = sp[AW-1:0];

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wr_idx;
    if (!rst && bus.push) begin
      if (bus.pop && !is_empty) begin
        wr_en   = 1'b1;
        wr_addr = top_idx;
      end else if (bus.pop || !is_full) begin
        wr_en   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp     <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (bus.pop) begin
      if (!is_empty) begin
        dout_q <= mem[top_idx];
        if (!bus.push) sp <= sp - CW'(1);
      end else begin
        udf_q <= 1'b1;
        if (bus.push) sp <= sp + CW'(1);
      end
    end else begin
      if (bus.tos) begin
        if (!is_empty) dout_q <= mem[top_idx];
        else           udf_q  <= 1'b1;
      end
      if (bus.push) begin
        if (!is_full) sp    <= sp + CW'(1);
        else          ovf_q <= 1'b1;
      end
    end
  end

  assign bus.dout  = dout_q;
  assign bus.count = sp;
  assign bus.empty = is_empty;
  assign bus.full  = is_full;
  assign bus.ovf   = ovf_q;
  assign bus.udf   = udf_q;
endmodule

// File: tb/tb_sbmips_stack.sv
// Randomized and directed self-checking bench for sbmips_stack against a queue model.
module tb_sbmips_stack;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  sbmips_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  sbmips_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Behavioural model: the stack is a queue whose back is the top entry.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_ovf;
  logic             m_udf;

  task automatic model_step(input logic r, input logic p, input logic po,
                            input logic t, input logic [WIDTH-1:0] d);
    if (r) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else if (po) begin
      if (q.size() > 0) begin
        m_dout = q[$];
        if (p) q[q.size()-1] = d;
        else   void'(q.pop_back());
      end else begin
        m_udf = 1'b1;
        if (p) q.push_back(d);
      end
    end else begin
      if (t) begin
        if (q.size() > 0) m_dout = q[$];
        else              m_udf  = 1'b1;
      end
      if (p) begin
        if (q.size() < DEPTH) q.push_back(d);
        else                  m_ovf = 1'b1;
      end
    end
  endtask

  // Apply one cycle of strobes (called #1 after an edge), sample #1 after the next edge.
  task automatic op(input logic r, input logic p, input logic po,
                    input logic t, input logic [WIDTH-1:0] d);
    rst = r; bus.push = p; bus.pop = po; bus.tos = t; bus.din = d;
    @(posedge clk);
    #1;
    model_step(r, p, po, t, d);
    rst = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0;
  endtask

  task automatic do_reset();
    op(1'b1, 1'b0, 1'b0, 1'b0, '0);
    op(1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.count, bus.empty, bus.full, bus.dout, bus.ovf, bus.udf} !==
        {5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: count=%0d empty=%b full=%b dout=%h ovf=%b udf=%b expected 0 1 0 00 0 0",
               bus.count, bus.empty, bus.full, bus.dout, bus.ovf, bus.udf);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    op(1'b0, 1'b0, 1'b1, 1'b0, '0);
    checks++;
    if ({bus.udf, bus.count, bus.dout} !== {1'b1, 5'd0, 8'h00}) begin
      errors++;
      $display("FAIL underflow_pop: udf=%b count=%0d dout=%h expected 1 0 00", bus.udf, bus.count, bus.dout);
    end
    // Reset together with a push: reset must win and nothing is written.
    op(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A);
    checks++;
    if ({bus.udf, bus.count, bus.empty} !== {1'b0, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL underflow_rst_clear: udf=%b count=%0d empty=%b expected 0 0 1", bus.udf, bus.count, bus.empty);
    end
  endtask

  task automatic test_lifo();
    logic [WIDTH-1:0] exp_v [3];
    exp_v[0] = 8'h33; exp_v[1] = 8'h22; exp_v[2] = 8'h11;
    do_reset();
    op(1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
    op(1'b0, 1'b1, 1'b0, 1'b0, 8'h22);
    op(1'b0, 1'b1, 1'b0, 1'b0, 8'h33);
    checks++;
    if (bus.count !== 5'd3) begin
      errors++;
      $display("FAIL lifo_count_after_push: count=%0d expected 3", bus.count);
    end
    for (int i = 0; i < 3; i++) begin
      op(1'b0, 1'b0, 1'b1, 1'b0, '0);
      checks++;
      if ({bus.dout, bus.count} !== {exp_v[i], 5'(2 - i)}) begin
        errors++;
        $display("FAIL lifo_pop%0d: dout=%h count=%0d expected %h %0d", i, bus.dout, bus.count, exp_v[i], 2 - i);
      end
    end
    checks++;
    if (bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL lifo_empty: empty=%b expected 1", bus.empty);
    end
  endtask

  task automatic test_tos();
    do_reset();
    op(1'b0, 1'b1, 1'b0, 1'b0, 8'hA5);
    for (int i = 0; i < 2; i++) begin
      op(1'b0, 1'b0, 1'b0, 1'b1, '0);
      checks++;
      if ({bus.dout, bus.count} !== {8'hA5, 5'd1}) begin
        errors++;
        $display("FAIL tos_%0d: dout=%h count=%0d expected a5 1", i, bus.dout, bus.count);
      end
    end
  endtask

  task automatic fill_stack();
    do_reset();
    for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, 1'b0, 1'b0, 8'(i));
  endtask

  task automatic test_full_ovf();
    fill_stack();
    op(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    checks++;
    if ({bus.full, bus.count, bus.ovf} !== {1'b1, 5'd16, 1'b1}) begin
      errors++;
      $display("FAIL full_ovf: full=%b count=%0d ovf=%b expected 1 16 1", bus.full, bus.count, bus.ovf);
    end
    op(1'b0, 1'b0, 1'b1, 1'b0, '0);
    checks++;
    if ({bus.dout, bus.count, bus.full, bus.ovf} !== {8'h0F, 5'd15, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL full_pop: dout=%h count=%0d full=%b ovf=%b expected 0f 15 0 1",
               bus.dout, bus.count, bus.full, bus.ovf);
    end
  endtask

  task automatic test_replace();
    fill_stack();
    op(1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
    checks++;
    if ({bus.dout, bus.count, bus.ovf} !== {8'h0F, 5'd16, 1'b0}) begin
      errors++;
      $display("FAIL replace_top: dout=%h count=%0d ovf=%b expected 0f 16 0", bus.dout, bus.count, bus.ovf);
    end
    op(1'b0, 1'b0, 1'b0, 1'b1, '0);
    checks++;
    if (bus.dout !== 8'h77) begin
      errors++;
      $display("FAIL replace_tos: dout=%h expected 77", bus.dout);
    end
    // Push+pop on an empty stack behaves as a push and flags underflow.
    do_reset();
    op(1'b0, 1'b1, 1'b1, 1'b0, 8'h3C);
    checks++;
    if ({bus.count, bus.dout, bus.udf} !== {5'd1, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL replace_empty: count=%0d dout=%h udf=%b expected 1 00 1", bus.count, bus.dout, bus.udf);
    end
  endtask

  task automatic test_random();
    logic r, p, po, t;
    logic [WIDTH-1:0] d;
    logic [WIDTH+DEPTH-DEPTH+8:0] dummy;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      r  = ($urandom_range(0, 99) == 0);
      p  = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 35);
      t  = ($urandom_range(0, 99) < 25);
      d  = 8'($urandom);
      op(r, p, po, t, d);
      checks++;
      if ({bus.dout, bus.count, bus.empty, bus.full, bus.ovf, bus.udf} !==
          {m_dout, 5'(q.size()), q.size() == 0, q.size() == DEPTH, m_ovf, m_udf}) begin
        errors++;
        $display("FAIL random_step%0d: dout=%h count=%0d empty=%b full=%b ovf=%b udf=%b expected %h %0d %b %b %b %b",
                 n, bus.dout, bus.count, bus.empty, bus.full, bus.ovf, bus.udf,
                 m_dout, q.size(), q.size() == 0, q.size() == DEPTH, m_ovf, m_udf);
      end
    end
    dummy = '0;
  endtask

  initial begin
    rst = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0; bus.din = '0;
    m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_underflow();
    test_lifo();
    test_tos();
    test_full_ovf();
    test_replace();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sbmips_stack.md
# sbmips_stack

Hardware operand stack for the stack-based multicycle SBMIPS core. It sits directly downstream of the datapath's Push/Pop/Tos control lines: the control unit drives the operation strobes, the datapath supplies the write operand, and the block returns the top-of-stack word on a registered output for the ALU/Bld path. It also provides occupancy flags and sticky overflow/underflow error bits for debug.

## Interface
- WIDTH, 8, data word width (matches 8-bit SBMIPS memory words)
- DEPTH, 16, number of stack entries; must be a power of two, at least 2
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- push  in  1  write `din` onto the stack this cycle
- pop  in  1  remove the top entry this cycle and load it into `dout`
- tos  in  1  load the top entry into `dout` without removing it
- din  in  WIDTH  operand to push
- dout  out  WIDTH  registered top-of-stack read result
- count  out  $clog2(DEPTH)+1  current number of entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- ovf  out  1  sticky: a push was dropped because the stack was full
- udf  out  1  sticky: a pop or tos hit an empty stack

## Operation
- Storage is a DEPTH x WIDTH register array plus stack pointer `sp` (= count). The live top entry is `mem[sp-1]`. Array contents are not cleared by reset.
- Each cycle, the strobes are decoded as one of the following operations. All state updates occur at the rising edge.
  - **Idle** (no strobe): no change.
  - **tos only**:
    - not empty: `dout <= mem[sp-1]`.
    - empty: `dout` is unchanged and `udf <= 1`.
  - **pop** (tos is ignored when pop is asserted):
    - not empty: `dout <= mem[sp-1]` and `sp <= sp-1`.
    - empty: no change to `sp` or `dout`, and `udf <= 1`.
  - **push only**:
    - not full: `mem[sp] <= din` and `sp <= sp+1`.
    - full: the push is dropped, and `ovf <= 1`.
  - **push + tos**:
    - If not empty, `dout <= old mem[sp-1]`; if empty, `udf <= 1`.
    - The push then executes as for push only, including the full case.
  - **push + pop** (replace top):
    - not empty: `dout <= old mem[sp-1]`, `mem[sp-1] <= din`, and `sp` is unchanged. This is legal even when full, and `ovf` is not set.
    - empty: the push executes (`mem[0] <= din`, `sp <= 1`), `dout` is unchanged, and `udf <= 1`.
- `empty`, `full`, and `count` are combinational decodes of `sp`.
- `ovf` and `udf` are set-only and are cleared only by `rst`.
- Width rules:
  - `sp` is $clog2(DEPTH)+1 bits and never exceeds DEPTH or goes below 0.
  - The array index uses the low $clog2(DEPTH) bits.
  - `din` and `dout` are stored and returned unmodified.

## Timing
- Reset values: sp=0, count=0, empty=1, full=0, dout=0, ovf=0, udf=0.
- When `rst` is asserted in the same cycle as any strobe, reset wins and no write occurs.
- Read latency is 1 cycle: `dout` is valid on the edge after a pop or tos and holds until the next successful pop or tos.
- Push-to-visible latency is 1 cycle: a tos issued in the cycle after a push returns the pushed value.
- `count`, `empty`, and `full` reflect the new `sp` immediately after the edge.
- Back-to-back operations on consecutive cycles are fully supported with no bubbles; the block never stalls.
- Strobes are sampled every cycle. The control unit is responsible for pulsing them for exactly one cycle per micro-op.

## Test plan
- Reset state:
  - Stimulus: apply rst for 2 cycles, then release.
  - Required response: count=0, empty=1, full=0, dout=0, ovf=0, udf=0.
- LIFO order:
  - Stimulus: push 0x11, 0x22, 0x33 on consecutive cycles, then pop three times.
  - Required response: dout sequence is 0x33, 0x22, 0x11; count goes 3, 2, 1, 0; empty=1 at the end.
- Tos non-destructive:
  - Stimulus: push 0xA5, then tos twice.
  - Required response: dout=0xA5 both times; count stays 1.
- Full and overflow (DEPTH=16):
  - Stimulus: push 0..15, then push 0xFF.
  - Required response: full=1, count=16, ovf=1.
  - Follow-up: pop returns 0x0F, not 0xFF.
- Empty and underflow:
  - Stimulus: after reset, pop.
  - Required response: udf=1, count=0, dout=0.
  - Follow-up: a subsequent rst clears udf.
- Replace top:
  - Stimulus: with the stack full holding top value 0x0F, assert push+pop with din=0x77.
  - Required response: dout=0x0F, count=16, ovf=0.
  - Follow-up: a following tos returns 0x77.
